lamp_display_ctrl: RTL and testbench

Downstream stage of the calculator SoC. Consumes the 42-bit `lamps_export` word driven by the HPS-side PIO and drives six active-low seven-segment digits. A change to the lamp word is shown only after it has held steady for a programmable number of cycles, so partial PIO writes never tear the display. The block also applies global PWM dimming and per-digit blinking.

---
 rtl/lamp_display_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_lamp_display_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/lamp_display_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lamp_display_ctrl                                            |
// | Description : Debounced commit of the 42-bit lamp word onto six active-low |
// |               seven-segment digits, with global PWM dimming and optional   |
// |               per-digit blinking.                                          |
// | Options     : define LAMP_DISP_BLINK_EN to include the blink logic.        |
// |               Without it, blink_mask and blink_tick are ignored and every  |
// |               digit follows only the PWM gate.                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lamp_display_ctrl #(
  parameter int STABLE_CYCLES = 4,   // legal range 1..255
  parameter int PWM_BITS      = 4
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [41:0]         lamps_export,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic [5:0]          blink_mask,
  input  logic                blink_tick,
  output logic [6:0]          hex0,
  output logic [6:0]          hex1,
  output logic [6:0]          hex2,
  output logic [6:0]          hex3,
  output logic [6:0]          hex4,
  output logic [6:0]          hex5,
  output logic                update_pulse
);

  localparam logic [7:0]          STABLE_CNT = 8'(STABLE_CYCLES);
  localparam logic [PWM_BITS-1:0] PWM_FULL   = {PWM_BITS{1'b1}};

  typedef enum logic [1:0] {
    ST_STEADY = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Input capture
  // --------------------------------------------------------------------------
  logic [41:0] lamps_q;

  // Register the PIO word once; everything downstream sees only this copy.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      lamps_q <= '0;
    end else begin
      lamps_q <= lamps_export;
    end
  end

  // --------------------------------------------------------------------------
  // Commit FSM: a changed word must hold steady before it reaches disp
  // --------------------------------------------------------------------------
  state_t      state, state_nx;
  logic [41:0] disp, disp_nx;
  logic [41:0] cand, cand_nx;
  logic [7:0]  cnt, cnt_nx;
  logic        pulse_nx;

  // State and datapath registers of the commit FSM.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state        <= ST_STEADY;
      disp         <= '0;
      cand         <= '0;
      cnt          <= '0;
      update_pulse <= 1'b0;
    end else begin
      state        <= state_nx;
      disp         <= disp_nx;
      cand         <= cand_nx;
      cnt          <= cnt_nx;
      update_pulse <= pulse_nx;
    end
  end

  // Next-state logic; SETTLE checks revert, then restart, then count expiry.
  always_comb begin
    state_nx = state;
    disp_nx  = disp;
    cand_nx  = cand;
    cnt_nx   = cnt;
    pulse_nx = 1'b0;
    case (state)
      ST_STEADY: begin
        if (lamps_q != disp) begin
          cand_nx  = lamps_q;
          cnt_nx   = 8'd1;
          state_nx = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (lamps_q == disp) begin
          // The word returned to what is already shown: nothing to commit.
          cnt_nx   = 8'd0;
          state_nx = ST_STEADY;
        end else if (lamps_q != cand) begin
          // A newer value arrived; only the latest one may ever commit.
          cand_nx = lamps_q;
          cnt_nx  = 8'd1;
        end else if (cnt == STABLE_CNT) begin
          state_nx = ST_COMMIT;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      ST_COMMIT: begin
        // Any change that arrives now is picked up from STEADY next cycle.
        disp_nx  = cand;
        pulse_nx = 1'b1;
        state_nx = ST_STEADY;
      end
      default: begin
        state_nx = ST_STEADY;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // PWM dimming
  // --------------------------------------------------------------------------
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] bright_q;
  logic                pwm_on;

  // Free-running period counter; brightness is only sampled at the period
  // start so a duty change never produces a runt pulse mid-period.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      pwm_cnt  <= '0;
      bright_q <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_cnt == '0) begin
        bright_q <= brightness;
      end
    end
  end

  // All-ones is forced fully on; otherwise lit while the count is below duty.
  assign pwm_on = (bright_q == PWM_FULL) || (pwm_cnt < bright_q);

  // --------------------------------------------------------------------------
  // Blink
  // --------------------------------------------------------------------------
  logic       blink_phase;
  logic [5:0] blank;

`ifdef LAMP_DISP_BLINK_EN
  // Each tick strobe flips the shared blink phase.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      blink_phase <= 1'b0;
    end else if (blink_tick) begin
      blink_phase <= ~blink_phase;
    end
  end
`else
  // Blinking compiled out: phase is a constant and the tick is unused.
  logic unused_blink_tick;
  assign unused_blink_tick = blink_tick;
  assign blink_phase       = 1'b0;
`endif

  assign blank = blink_mask & {6{blink_phase}};

  // --------------------------------------------------------------------------
  // Output stage: active-low segment drive, one register per digit
  // --------------------------------------------------------------------------
  logic [6:0] seg_q [6];

  generate
    for (genvar k = 0; k < 6; k++) begin : g_digit
      logic gate;
      assign gate = pwm_on & ~blank[k];

      // Invert the lit pattern; a gated-off digit drives all segments dark.
      always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
          seg_q[k] <= 7'h7F;
        end else begin
          seg_q[k] <= ~(disp[7*k +: 7] & {7{gate}});
        end
      end
    end
  endgenerate

  assign hex0 = seg_q[0];
  assign hex1 = seg_q[1];
  assign hex2 = seg_q[2];
  assign hex3 = seg_q[3];
  assign hex4 = seg_q[4];
  assign hex5 = seg_q[5];

endmodule
`default_nettype wire

// File: tb/tb_lamp_display_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_lamp_display_ctrl                                         |
// | Description : Directed self-checking bench for lamp_display_ctrl with      |
// |               hand-computed expectations (STABLE_CYCLES=4, PWM_BITS=4).    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_lamp_display_ctrl;

  logic        clk_clk      = 1'b0;
  logic        reset_reset  = 1'b1;
  logic [41:0] lamps_export = '0;
  logic [3:0]  brightness   = '0;
  logic [5:0]  blink_mask   = '0;
  logic        blink_tick   = 1'b0;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic        update_pulse;
  logic [41:0] hex_all;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [41:0] ALL_DARK = {6{7'h7F}};

  always #5 clk_clk = ~clk_clk;

  assign hex_all = {hex5, hex4, hex3, hex2, hex1, hex0};

  lamp_display_ctrl #(
    .STABLE_CYCLES(4),
    .PWM_BITS     (4)
  ) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .lamps_export(lamps_export),
    .brightness  (brightness),
    .blink_mask  (blink_mask),
    .blink_tick  (blink_tick),
    .hex0        (hex0),
    .hex1        (hex1),
    .hex2        (hex2),
    .hex3        (hex3),
    .hex4        (hex4),
    .hex5        (hex5),
    .update_pulse(update_pulse)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int pulses;
    int pidx;
    int bad;
    int lit;

    // ---- reset state ----
    repeat (3) @(negedge clk_clk);
    check_val("reset_hex", hex_all, ALL_DARK);
    check_val("reset_pulse", update_pulse, 1'b0);

    reset_reset = 1'b0;
    brightness  = 4'hF;
    repeat (20) @(negedge clk_clk);
    check_val("idle_hex", hex_all, ALL_DARK);

    // ---- clean update: pulse after E0+6, hex after E0+7 ----
    lamps_export = 42'h3F;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk_clk);
      check_val($sformatf("clean_pulse_%0d", i), update_pulse, (i == 7));
      if (i == 7) check_val("clean_hex_before", hex_all, ALL_DARK);
    end
    check_val("clean_hex", hex_all, {{5{7'h7F}}, 7'h40});

    // ---- glitch rejection: 2-cycle blip then revert ----
    lamps_export = 42'h06;
    repeat (2) @(negedge clk_clk);
    lamps_export = 42'h3F;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_clk);
      if (update_pulse) pulses++;
      check_val("glitch_hex0", hex0, 7'h40);
    end
    check_val("glitch_pulses", pulses, 0);

    // ---- restart: 06 for 2 cycles, then 5B held ----
    lamps_export = 42'h06;
    repeat (2) @(negedge clk_clk);
    lamps_export = 42'h5B;
    pulses = 0;
    pidx   = 0;
    bad    = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk_clk);
      if (update_pulse) begin
        pulses++;
        pidx = i;
      end
      if (hex0 == 7'h79) bad++;
    end
    check_val("restart_pulses", pulses, 1);
    check_val("restart_pulse_pos", pidx, 7);
    check_val("restart_no_06", bad, 0);
    check_val("restart_hex0", hex0, 7'h24);

    // ---- PWM: brightness 4 -> 4 lit of every 16 ----
    brightness = 4'd4;
    repeat (40) @(negedge clk_clk);
    lit = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk_clk);
      if (hex0 != 7'h7F) begin
        lit++;
        check_val("pwm_lit_value", hex0, 7'h24);
      end
    end
    check_val("pwm4_lit_count", lit, 8);

    // brightness 0 -> dark after the next wrap
    brightness = 4'd0;
    repeat (20) @(negedge clk_clk);
    lit = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_clk);
      if (hex0 != 7'h7F) lit++;
    end
    check_val("pwm0_lit_count", lit, 0);

    // brightness all-ones -> always lit
    brightness = 4'hF;
    repeat (20) @(negedge clk_clk);
    lit = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_clk);
      if (hex0 == 7'h24) lit++;
    end
    check_val("pwm15_lit_count", lit, 16);

    // ---- blink: commit two digits, then toggle digit 0 ----
    lamps_export = (42'h06 << 7) | 42'h3F;
    repeat (12) @(negedge clk_clk);
    check_val("blink_pre_hex", hex_all, {{4{7'h7F}}, 7'h79, 7'h40});

    blink_mask = 6'b000001;
    @(negedge clk_clk);
    check_val("blink_mask_only", hex0, 7'h40);
    blink_tick = 1'b1;
    @(negedge clk_clk);
    blink_tick = 1'b0;
    @(negedge clk_clk);
`ifdef LAMP_DISP_BLINK_EN
    check_val("blink_tick1_hex", hex_all, {{4{7'h7F}}, 7'h79, 7'h7F});
`else
    check_val("blink_tick1_hex", hex_all, {{4{7'h7F}}, 7'h79, 7'h40});
`endif
    blink_tick = 1'b1;
    @(negedge clk_clk);
    blink_tick = 1'b0;
    @(negedge clk_clk);
    check_val("blink_tick2_hex", hex_all, {{4{7'h7F}}, 7'h79, 7'h40});
    blink_mask = 6'b000000;

    // ---- reset mid-SETTLE ----
    lamps_export = 42'h5B;
    repeat (3) @(negedge clk_clk);
    check_val("pre_reset_hex0", hex0, 7'h40);
    reset_reset = 1'b1;
    #1;
    check_val("midrst_hex", hex_all, ALL_DARK);
    check_val("midrst_pulse", update_pulse, 1'b0);
    lamps_export = '0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_clk);
      if (update_pulse) pulses++;
      check_val("rst_hold_hex", hex_all, ALL_DARK);
    end
    reset_reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_clk);
      if (update_pulse) pulses++;
      check_val("post_rst_hex", hex_all, ALL_DARK);
    end
    check_val("post_rst_pulses", pulses, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
